julia_escape_iter: RTL and testbench

- Upstream stage of the `naturallog` lookup.
- For each pixel it iterates z(n+1) = z(n)^2 + c in signed Q16.16 until |z|^2 > 4.0 or until MAX_ITER checks have passed.
- It then emits the escape iteration count, which lies in the range 1..MAX_ITER+1. With the default MAX_ITER = 100 this is exactly the 1..101 input domain of `naturallog`.
- One iteration per clock; valid/ready handshakes on both the input and the output side.

---
 rtl/julia_pkg.sv | 11 +
 rtl/fxp_mul.sv | 22 ++
 rtl/julia_escape_iter.sv | 138 +++++++++++++
 tb/tb_julia_escape_iter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared fixed-point types, escape threshold and FSM encoding for the Julia escape iterator.
package julia_pkg;

  typedef logic signed [31:0] fixed_t;

  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] ESCAPE_R2 = 32'h0004_0000;

  typedef enum logic [1:0] {IDLE, ITER, DONE} iter_state_t;

endpackage

// File: rtl/fxp_mul.sv
// Combinational signed Q16.16 multiply returning product bits [47:16]
// plus a flag raised when the full product does not fit that window.
module fxp_mul
  import julia_pkg::*;
(
  input  fixed_t a_i,
  input  fixed_t b_i,
  output fixed_t p_o,
  output logic   ovf_o
);

  logic signed [63:0] prod_full;
  logic signed [47:0] prod_sh;

  assign prod_full = 64'(a_i) * 64'(b_i);
  assign prod_sh   = 48'(prod_full >>> FRAC_BITS);

  // Bits above the kept window must all copy its sign bit.
  assign ovf_o = ~((&prod_sh[47:31]) | ~(|prod_sh[47:31]));
  assign p_o   = prod_sh[31:0];

endmodule

// File: rtl/julia_escape_iter.sv
// Julia-set escape counter: one z^2+c step per clock, result count 1..MAX_ITER+1.
// Optional JULIA_SMOOTH_MAG_EN adds out_mag2 (|z|^2 at escape, saturated).
module julia_escape_iter
  import julia_pkg::*;
#(
  parameter int unsigned MAX_ITER = 100
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] z0_re,
  input  logic [31:0] z0_im,
  input  logic [31:0] c_re,
  input  logic [31:0] c_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_iter,
  output logic        out_escaped
`ifdef JULIA_SMOOTH_MAG_EN
  ,
  output logic [31:0] out_mag2
`endif
);

  iter_state_t state_q, state_d;
  fixed_t      zr_q, zr_d, zi_q, zi_d;
  fixed_t      cr_q, cr_d, ci_q, ci_d;
  logic [31:0] count_q, count_d;
  logic [31:0] iter_q, iter_d;
  logic        esc_q, esc_d;

  fixed_t      rr, ii, ri;
  logic        rr_ovf, ii_ovf, ri_ovf, any_ovf;
  logic [32:0] mag2;
  logic        escape;

  fxp_mul u_mul_rr (.a_i(zr_q), .b_i(zr_q), .p_o(rr), .ovf_o(rr_ovf));
  fxp_mul u_mul_ii (.a_i(zi_q), .b_i(zi_q), .p_o(ii), .ovf_o(ii_ovf));
  fxp_mul u_mul_ri (.a_i(zr_q), .b_i(zi_q), .p_o(ri), .ovf_o(ri_ovf));

  // Without overflow both squares are non-negative, so an unsigned 33-bit sum is exact.
  assign any_ovf = rr_ovf | ii_ovf | ri_ovf;
  assign mag2    = {rr[31], rr} + {ii[31], ii};
  assign escape  = any_ovf | (mag2 > 33'(ESCAPE_R2));

`ifdef JULIA_SMOOTH_MAG_EN
  logic [31:0] mag_q, mag_d;
`endif

  always_comb begin
    state_d = state_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    count_d = count_q;
    iter_d  = iter_q;
    esc_d   = esc_q;
`ifdef JULIA_SMOOTH_MAG_EN
    mag_d   = mag_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          zr_d    = z0_re;
          zi_d    = z0_im;
          cr_d    = c_re;
          ci_d    = c_im;
          count_d = 32'd1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (escape) begin
          iter_d  = count_q;
          esc_d   = 1'b1;
`ifdef JULIA_SMOOTH_MAG_EN
          mag_d   = any_ovf ? 32'hFFFF_FFFF : mag2[31:0];
`endif
          state_d = DONE;
        end else if (count_q == MAX_ITER) begin
          iter_d  = MAX_ITER + 32'd1;
          esc_d   = 1'b0;
`ifdef JULIA_SMOOTH_MAG_EN
          mag_d   = 32'd0;
`endif
          state_d = DONE;
        end else begin
          zr_d    = rr - ii + cr_q;
          zi_d    = ri + ri + ci_q;
          count_d = count_q + 32'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      count_q <= '0;
      iter_q  <= '0;
      esc_q   <= 1'b0;
`ifdef JULIA_SMOOTH_MAG_EN
      mag_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      count_q <= count_d;
      iter_q  <= iter_d;
      esc_q   <= esc_d;
`ifdef JULIA_SMOOTH_MAG_EN
      mag_q   <= mag_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_iter    = iter_q;
  assign out_escaped = esc_q;
`ifdef JULIA_SMOOTH_MAG_EN
  assign out_mag2    = mag_q;
`endif

endmodule

// File: tb/tb_julia_escape_iter.sv
// Self-checking bench for julia_escape_iter: directed corner cases plus random pixels vs. an arithmetic model.
module tb_julia_escape_iter;

  localparam int unsigned MAX_ITER = 100;
  localparam int ONE = 65536;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] z0_re, z0_im, c_re, c_im;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_iter;
  logic        out_escaped;
`ifdef JULIA_SMOOTH_MAG_EN
  logic [31:0] out_mag2;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  julia_escape_iter #(.MAX_ITER(MAX_ITER)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z0_re      (z0_re),
    .z0_im      (z0_im),
    .c_re       (c_re),
    .c_im       (c_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_iter   (out_iter),
    .out_escaped(out_escaped)
`ifdef JULIA_SMOOTH_MAG_EN
    ,
    .out_mag2   (out_mag2)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference: iterate the escape rule in 64-bit arithmetic, truncating like Q16.16 hardware would.
  function automatic void ref_pixel(input int zr0, input int zi0, input int cr, input int ci,
                                    output int iter, output bit esc, output int unsigned mag);
    longint zr, zi, rr, ii, ri, m;
    bit ovf;
    zr = zr0;
    zi = zi0;
    iter = MAX_ITER + 1;
    esc = 1'b0;
    mag = 0;
    for (int k = 1; k <= MAX_ITER; k++) begin
      rr = (zr * zr) >>> 16;
      ii = (zi * zi) >>> 16;
      ri = (zr * zi) >>> 16;
      ovf = (rr > 64'sd2147483647) || (ii > 64'sd2147483647) ||
            (ri > 64'sd2147483647) || (ri < -64'sd2147483648);
      m = rr + ii;
      if (ovf || m > 64'sd262144) begin
        iter = k;
        esc = 1'b1;
        mag = ovf ? 32'hFFFF_FFFF : 32'(m);
        return;
      end
      zr = longint'(int'(rr - ii + cr));
      zi = longint'(int'(2 * ri + ci));
    end
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic drive_px(input int zr, input int zi, input int cr, input int ci);
    in_valid = 1'b1;
    z0_re = zr;
    z0_im = zi;
    c_re = cr;
    c_im = ci;
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input int delay);
    repeat (delay) begin
      @(posedge Clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge Clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    z0_re = '0; z0_im = '0; c_re = '0; c_im = '0;
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_iter !== 32'd0) begin n_fail++; $display("FAIL reset_out_iter got=%0d want=0", out_iter); end
    n_cmp++; if (out_escaped !== 1'b0) begin n_fail++; $display("FAIL reset_out_escaped got=%b want=0", out_escaped); end
`ifdef JULIA_SMOOTH_MAG_EN
    n_cmp++; if (out_mag2 !== 32'd0) begin n_fail++; $display("FAIL reset_out_mag2 got=%h want=0", out_mag2); end
`endif
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_escape_first();
    int lat;
    drive_px(3 * ONE, 0, 0, 0);
    wait_result(lat);
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL first_latency got=%0d want=1", lat); end
    n_cmp++; if (out_iter !== 32'd1) begin n_fail++; $display("FAIL first_iter got=%0d want=1", out_iter); end
    n_cmp++; if (out_escaped !== 1'b1) begin n_fail++; $display("FAIL first_escaped got=%b want=1", out_escaped); end
`ifdef JULIA_SMOOTH_MAG_EN
    n_cmp++; if (out_mag2 !== 32'h0009_0000) begin n_fail++; $display("FAIL first_mag2 got=%h want=00090000", out_mag2); end
`endif
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL first_in_ready_done got=%b want=0", in_ready); end
    consume(0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL first_after_hs got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_boundary();
    int lat;
    drive_px(ONE, 0, ONE, 0);
    wait_result(lat);
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL bound_latency got=%0d want=3", lat); end
    n_cmp++; if (out_iter !== 32'd3) begin n_fail++; $display("FAIL bound_iter got=%0d want=3", out_iter); end
    n_cmp++; if (out_escaped !== 1'b1) begin n_fail++; $display("FAIL bound_escaped got=%b want=1", out_escaped); end
`ifdef JULIA_SMOOTH_MAG_EN
    n_cmp++; if (out_mag2 !== 32'h0019_0000) begin n_fail++; $display("FAIL bound_mag2 got=%h want=00190000", out_mag2); end
`endif
    consume(0);
  endtask

  task automatic test_max_iter();
    int lat;
    drive_px(0, 0, 0, 0);
    wait_result(lat);
    n_cmp++; if (lat != int'(MAX_ITER)) begin n_fail++; $display("FAIL max_latency got=%0d want=%0d", lat, MAX_ITER); end
    n_cmp++; if (out_iter !== MAX_ITER + 1) begin n_fail++; $display("FAIL max_iter got=%0d want=%0d", out_iter, MAX_ITER + 1); end
    n_cmp++; if (out_escaped !== 1'b0) begin n_fail++; $display("FAIL max_escaped got=%b want=0", out_escaped); end
`ifdef JULIA_SMOOTH_MAG_EN
    n_cmp++; if (out_mag2 !== 32'd0) begin n_fail++; $display("FAIL max_mag2 got=%h want=0", out_mag2); end
`endif
    consume(0);
  endtask

  task automatic test_hold();
    int lat;
    drive_px(3 * ONE, 0, 0, 0);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      z0_re = 0;
      @(posedge Clk);
      #1;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_iter !== 32'd1 || out_escaped !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d got valid=%b iter=%0d esc=%b ready=%b want 1/1/1/0",
                           i, out_valid, out_iter, out_escaped, in_ready);
      end
    end
    consume(0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_handshake got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge Clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_no_phantom got ready=%b want=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    drive_px(0, 0, 0, 0);
    repeat (39) begin
      @(posedge Clk);
      #1;
    end
    Reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_iter !== 32'd0) begin
      n_fail++; $display("FAIL midreset got valid=%b ready=%b iter=%0d want 0/1/0", out_valid, in_ready, out_iter);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    drive_px(3 * ONE, 0, 0, 0);
    wait_result(lat);
    n_cmp++; if (lat != 1 || out_iter !== 32'd1) begin
      n_fail++; $display("FAIL midreset_next got lat=%0d iter=%0d want 1/1", lat, out_iter);
    end
    consume(0);
  endtask

  task automatic test_random();
    int zr, zi, cr, ci, lat, e_iter;
    bit e_esc;
    int unsigned e_mag;
    for (int n = 0; n < 30; n++) begin
      zr = int'($urandom_range(327680)) - 163840;
      zi = int'($urandom_range(327680)) - 163840;
      cr = int'($urandom_range(157286)) - 78643;
      ci = int'($urandom_range(157286)) - 78643;
      ref_pixel(zr, zi, cr, ci, e_iter, e_esc, e_mag);
      drive_px(zr, zi, cr, ci);
      wait_result(lat);
      n_cmp++; if (out_iter !== e_iter || out_escaped !== e_esc) begin
        n_fail++; $display("FAIL rand%0d_result got iter=%0d esc=%b want iter=%0d esc=%b", n, out_iter, out_escaped, e_iter, e_esc);
      end
      n_cmp++; if (lat != (e_esc ? e_iter : int'(MAX_ITER))) begin
        n_fail++; $display("FAIL rand%0d_latency got=%0d want=%0d", n, lat, e_esc ? e_iter : int'(MAX_ITER));
      end
`ifdef JULIA_SMOOTH_MAG_EN
      n_cmp++; if (out_mag2 !== e_mag) begin n_fail++; $display("FAIL rand%0d_mag2 got=%h want=%h", n, out_mag2, e_mag); end
`endif
      consume(int'($urandom_range(3)));
    end
  endtask

  task automatic test_back_to_back();
    int zr, zi, cr, ci, lat, e_iter;
    bit e_esc;
    int unsigned e_mag;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (n == 0) begin zr = 3 * ONE; zi = 0; cr = 0; ci = 0; end
      else if (n == 1) begin zr = 0; zi = 0; cr = 0; ci = 0; end
      else begin
        zr = int'($urandom_range(262144)) - 131072;
        zi = int'($urandom_range(262144)) - 131072;
        cr = int'($urandom_range(131072)) - 65536;
        ci = int'($urandom_range(131072)) - 65536;
      end
      ref_pixel(zr, zi, cr, ci, e_iter, e_esc, e_mag);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_in_ready got=%b want=1", n, in_ready); end
      drive_px(zr, zi, cr, ci);
      wait_result(lat);
      n_cmp++; if (out_iter !== e_iter || out_escaped !== e_esc) begin
        n_fail++; $display("FAIL b2b%0d_result got iter=%0d esc=%b want iter=%0d esc=%b", n, out_iter, out_escaped, e_iter, e_esc);
      end
`ifdef JULIA_SMOOTH_MAG_EN
      n_cmp++; if (out_mag2 !== e_mag) begin n_fail++; $display("FAIL b2b%0d_mag2 got=%h want=%h", n, out_mag2, e_mag); end
`endif
      @(posedge Clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_escape_first();
    test_boundary();
    test_max_iter();
    test_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
